mux_sequencer: RTL and testbench

Round-robin scheduler that drives the `sel` and `clken` inputs of a `latched_mux`. It steps through the enabled inputs in order. On each input it waits a settle interval, pulses `clken` for one cycle to latch that input, then holds for a programmable dwell before moving on. It sits between the register-mapped control bank and the mux, and replaces direct software writes to `sel`.

---
 rtl/mux_sequencer_pkg.sv | 23 ++
 rtl/mux_sequencer_if.sv | 29 ++
 rtl/mux_sequencer_rr_next_index.sv | 37 +++
 rtl/mux_sequencer.sv | 138 +++++++++++++
 tb/tb_mux_sequencer.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux_sequencer_pkg.sv
// Shared definitions for the mux_sequencer block: FSM state encoding,
// the default settle interval and the parameter legality check.
package mux_sequencer_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t LATCH  = 2'd2;
  localparam state_t DWELL  = 2'd3;

  localparam int SETTLE_CYCLES_DEFAULT = 2;

  // The settle count shares the dwell counter width, so it must fit in it.
  function automatic bit params_legal(input int n_inputs, input int sel_width,
                                      input int dwell_width, input int settle_cycles);
    return (n_inputs >= 1) && (sel_width >= 1) && (sel_width < 31) &&
           ((1 << sel_width) >= n_inputs) &&
           (dwell_width >= 1) && (dwell_width < 31) &&
           (settle_cycles >= 1) && (settle_cycles < (1 << dwell_width));
  endfunction

endpackage

// File: rtl/mux_sequencer_if.sv
// Control/strobe bundle between the register bank (master) and the
// mux_sequencer (slave); sel/clken continue on to the latched_mux.
interface mux_sequencer_if #(
  parameter int N_INPUTS    = 3,
  parameter int SEL_WIDTH   = 2,
  parameter int DWELL_WIDTH = 16
);

  logic                   start;
  logic                   stop;
  logic [N_INPUTS-1:0]    enable_mask;
  logic [DWELL_WIDTH-1:0] dwell;
  logic [SEL_WIDTH-1:0]   sel;
  logic                   clken;
  logic                   busy;
  logic                   round_done;
  logic                   mask_err;

  modport master (
    output start, stop, enable_mask, dwell,
    input  sel, clken, busy, round_done, mask_err
  );

  modport slave (
    input  start, stop, enable_mask, dwell,
    output sel, clken, busy, round_done, mask_err
  );

endinterface

// File: rtl/mux_sequencer_rr_next_index.sv
// Combinational round-robin finder: first set mask bit strictly above cur,
// else the lowest set bit (wrap); none flags an all-zero mask.
module rr_next_index #(
  parameter int N_INPUTS  = 3,
  parameter int SEL_WIDTH = 2
) (
  input  logic [SEL_WIDTH-1:0] cur,
  input  logic [N_INPUTS-1:0]  mask,
  output logic [SEL_WIDTH-1:0] nxt,
  output logic                 wrap,
  output logic                 none
);

  logic [SEL_WIDTH-1:0] lowest;
  logic [SEL_WIDTH-1:0] above;
  logic                 found;

  // Scan high-to-low so the last hit recorded is the lowest qualifying index.
  always_comb begin
    lowest = '0;
    above  = '0;
    found  = 1'b0;
    for (int i = N_INPUTS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = SEL_WIDTH'(i);
        if (i > int'(cur)) begin
          above = SEL_WIDTH'(i);
          found = 1'b1;
        end
      end
    end
    none = (mask == '0);
    wrap = !found && !none;
    nxt  = found ? above : lowest;
  end

endmodule

// File: rtl/mux_sequencer.sv
// Round-robin scheduler for a latched_mux: per enabled input it settles,
// strobes clken once, then dwells before stepping to the next input.
module mux_sequencer
  import mux_sequencer_pkg::*;
#(
  parameter int N_INPUTS      = 3,
  parameter int SEL_WIDTH     = 2,
  parameter int DWELL_WIDTH   = 16,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  mux_sequencer_if.slave bus
);

  localparam logic [DWELL_WIDTH-1:0] ONE         = DWELL_WIDTH'(1);
  localparam logic [DWELL_WIDTH-1:0] SETTLE_LAST = DWELL_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0]   TOP_INDEX   = SEL_WIDTH'(N_INPUTS - 1);

  if (!params_legal(N_INPUTS, SEL_WIDTH, DWELL_WIDTH, SETTLE_CYCLES)) begin : g_bad_params
    $error("mux_sequencer: illegal parameter combination");
  end

  function automatic logic [DWELL_WIDTH-1:0] clamp_dwell(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? ONE : d;
  endfunction

  state_t                 state, state_nx;
  logic [SEL_WIDTH-1:0]   sel_r, sel_d;
  logic                   clken_r, clken_d;
  logic                   busy_r, busy_d;
  logic                   round_done_r, round_done_d;
  logic                   mask_err_r, mask_err_d;
  logic [N_INPUTS-1:0]    mask_s;
  logic [DWELL_WIDTH-1:0] dwell_s;
  logic [DWELL_WIDTH-1:0] dw_eff;
  logic [DWELL_WIDTH-1:0] settle_cnt;
  logic [DWELL_WIDTH-1:0] dwell_cnt;
  logic [SEL_WIDTH-1:0]   rr_cur, rr_nxt;
  logic [N_INPUTS-1:0]    rr_mask;
  logic                   rr_wrap, rr_none;
  logic                   settle_end, dwell_end, dwell_last_next;
  logic                   launch_ok, step_ok;

  // From IDLE, searching above the top index yields the lowest enabled input.
  // On the LATCH cycle the live mask/dwell are the ones being sampled.
  always_comb begin
    rr_cur  = (state == IDLE) ? TOP_INDEX : sel_r;
    rr_mask = ((state == IDLE) || (state == LATCH)) ? bus.enable_mask : mask_s;
    dw_eff  = (state == LATCH) ? clamp_dwell(bus.dwell) : dwell_s;
  end

  rr_next_index #(
    .N_INPUTS  (N_INPUTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr (
    .cur  (rr_cur),
    .mask (rr_mask),
    .nxt  (rr_nxt),
    .wrap (rr_wrap),
    .none (rr_none)
  );

  assign settle_end      = (settle_cnt == SETTLE_LAST);
  assign dwell_end       = (dwell_cnt == dw_eff - ONE);
  // True when the upcoming cycle is the final DWELL cycle; round_done is
  // registered one cycle early so it lands on that cycle.
  assign dwell_last_next = ((state == LATCH) && (dw_eff == ONE)) ||
                           ((state == DWELL) && (dwell_cnt + ONE == dw_eff - ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start && !bus.stop && !rr_none) state_nx = SETTLE;
      SETTLE:  if (bus.stop) state_nx = IDLE;
               else if (settle_end) state_nx = LATCH;
      LATCH:   state_nx = bus.stop ? IDLE : DWELL;
      DWELL:   if (bus.stop) state_nx = IDLE;
               else if (dwell_end) state_nx = rr_none ? IDLE : SETTLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel_d     = sel_r;
    launch_ok = (state == IDLE) && bus.start && !bus.stop;
    step_ok   = (state == DWELL) && dwell_end && !bus.stop;
    if ((launch_ok || step_ok) && !rr_none) sel_d = rr_nxt;
    clken_d      = (state_nx == LATCH);
    busy_d       = (state_nx != IDLE);
    round_done_d = !bus.stop && dwell_last_next && rr_wrap;
    mask_err_d   = (launch_ok || step_ok) && rr_none;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r        <= '0;
      clken_r      <= 1'b0;
      busy_r       <= 1'b0;
      round_done_r <= 1'b0;
      mask_err_r   <= 1'b0;
    end else begin
      sel_r        <= sel_d;
      clken_r      <= clken_d;
      busy_r       <= busy_d;
      round_done_r <= round_done_d;
      mask_err_r   <= mask_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle_cnt <= '0;
      dwell_cnt  <= '0;
      mask_s     <= '0;
      dwell_s    <= '0;
    end else begin
      settle_cnt <= ((state == SETTLE) && (state_nx == SETTLE)) ? settle_cnt + ONE : '0;
      dwell_cnt  <= ((state == DWELL) && (state_nx == DWELL)) ? dwell_cnt + ONE : '0;
      if (state == LATCH) begin
        mask_s  <= bus.enable_mask;
        dwell_s <= dw_eff;
      end
    end
  end

  assign bus.sel        = sel_r;
  assign bus.clken      = clken_r;
  assign bus.busy       = busy_r;
  assign bus.round_done = round_done_r;
  assign bus.mask_err   = mask_err_r;

endmodule

// File: tb/tb_mux_sequencer.sv
// Scoreboard bench for mux_sequencer: expected clken/round_done/mask_err
// events (cycle and sel) are queued at stimulus time and popped on output.
module tb_mux_sequencer;

  localparam int N_INPUTS      = 3;
  localparam int SEL_WIDTH     = 2;
  localparam int DWELL_WIDTH   = 16;
  localparam int SETTLE_CYCLES = 2;

  typedef struct {
    int cyc;
    int sel;
  } strobe_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      cyc = 0;
  int      checks = 0;
  int      failures = 0;
  strobe_t strobe_q[$];
  int      round_q[$];
  int      err_q[$];

  mux_sequencer_if #(
    .N_INPUTS    (N_INPUTS),
    .SEL_WIDTH   (SEL_WIDTH),
    .DWELL_WIDTH (DWELL_WIDTH)
  ) bus ();

  mux_sequencer #(
    .N_INPUTS      (N_INPUTS),
    .SEL_WIDTH     (SEL_WIDTH),
    .DWELL_WIDTH   (DWELL_WIDTH),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic monitor();
    strobe_t e;
    int      c;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.clken === 1'b1) begin
          checks++;
          if (strobe_q.size() == 0) begin
            failures++;
            $display("FAIL clken_unexpected: got strobe at cyc=%0d sel=%0d, expected none", cyc, bus.sel);
          end else begin
            e = strobe_q.pop_front();
            if (cyc !== e.cyc || int'(bus.sel) !== e.sel) begin
              failures++;
              $display("FAIL clken_event: got cyc=%0d sel=%0d, expected cyc=%0d sel=%0d", cyc, bus.sel, e.cyc, e.sel);
            end
          end
        end
        if (bus.round_done === 1'b1) begin
          checks++;
          if (round_q.size() == 0) begin
            failures++;
            $display("FAIL round_done_unexpected: got pulse at cyc=%0d, expected none", cyc);
          end else begin
            c = round_q.pop_front();
            if (cyc !== c) begin
              failures++;
              $display("FAIL round_done_event: got cyc=%0d, expected cyc=%0d", cyc, c);
            end
          end
        end
        if (bus.mask_err === 1'b1) begin
          checks++;
          if (err_q.size() == 0) begin
            failures++;
            $display("FAIL mask_err_unexpected: got pulse at cyc=%0d, expected none", cyc);
          end else begin
            c = err_q.pop_front();
            if (cyc !== c) begin
              failures++;
              $display("FAIL mask_err_event: got cyc=%0d, expected cyc=%0d", cyc, c);
            end
          end
        end
      end
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_strobe(input int c, input int s);
    strobe_t e;
    e.cyc = c;
    e.sel = s;
    strobe_q.push_back(e);
  endtask

  // seq lists the sel order; its final character is only the index that
  // follows the last channel run, used to decide whether that channel wraps.
  task automatic run_rotation(input string name, input logic [2:0] mask,
                              input logic [15:0] dw, input string seq);
    int p, n, t0, cur, nxt;
    p = SETTLE_CYCLES + 1 + ((dw == 16'd0) ? 1 : int'(dw));
    n = seq.len() - 1;
    @(negedge clk);
    bus.enable_mask = mask;
    bus.dwell       = dw;
    bus.start       = 1'b1;
    t0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      cur = int'(seq.getc(i)) - 48;
      nxt = int'(seq.getc(i + 1)) - 48;
      push_strobe(t0 + SETTLE_CYCLES + i * p, cur);
      if (nxt <= cur) round_q.push_back(t0 + (i + 1) * p - 1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL %s_busy_after_start: got %b, expected 1", name, bus.busy);
    end
    checks++;
    if (int'(bus.sel) !== int'(seq.getc(0)) - 48) begin
      failures++;
      $display("FAIL %s_first_sel: got %0d, expected %0d", name, bus.sel, int'(seq.getc(0)) - 48);
    end
    wait_cyc(t0 + n * p - 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.clken !== 1'b0) begin
      failures++;
      $display("FAIL %s_stop_idle: got busy=%b clken=%b, expected 0 0", name, bus.busy, bus.clken);
    end
    checks++;
    if (int'(bus.sel) !== int'(seq.getc(n - 1)) - 48) begin
      failures++;
      $display("FAIL %s_sel_held: got %0d, expected %0d", name, bus.sel, int'(seq.getc(n - 1)) - 48);
    end
    checks++;
    if (strobe_q.size() + round_q.size() + err_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing_events: got %0d outstanding, expected 0", name,
               strobe_q.size() + round_q.size() + err_q.size());
    end
    strobe_q.delete(); round_q.delete(); err_q.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.sel !== 2'd0 || bus.clken !== 1'b0 || bus.busy !== 1'b0 ||
        bus.round_done !== 1'b0 || bus.mask_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: got sel=%0d clken=%b busy=%b round_done=%b mask_err=%b, expected all 0",
               bus.sel, bus.clken, bus.busy, bus.round_done, bus.mask_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.clken !== 1'b0 || bus.sel !== 2'd0) begin
      failures++;
      $display("FAIL reset_idle_hold: got busy=%b clken=%b sel=%0d, expected 0 0 0", bus.busy, bus.clken, bus.sel);
    end
  endtask

  task automatic test_basic_rotation();
    run_rotation("basic", 3'b111, 16'd4, "0120120");
  endtask

  task automatic test_sparse_mask();
    run_rotation("sparse", 3'b101, 16'd4, "02020");
    run_rotation("single", 3'b010, 16'd4, "1111");
  endtask

  task automatic test_zero_dwell();
    run_rotation("dwell0", 3'b111, 16'd0, "0120120");
    run_rotation("dwell1", 3'b111, 16'd1, "0120120");
  endtask

  task automatic test_mask_errors();
    int t0;
    @(negedge clk);
    bus.enable_mask = 3'b000;
    bus.dwell       = 16'd4;
    bus.start       = 1'b1;
    t0 = cyc + 1;
    err_q.push_back(t0);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_mask_busy: got %b, expected 0", bus.busy);
    end
    // Mask cleared during the first channel's dwell is picked up at the
    // second channel's LATCH and reported when that channel's dwell ends.
    @(negedge clk);
    bus.enable_mask = 3'b111;
    bus.start       = 1'b1;
    t0 = cyc + 1;
    push_strobe(t0 + 2, 0);
    push_strobe(t0 + 9, 1);
    err_q.push_back(t0 + 14);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(t0 + 4);
    bus.enable_mask = 3'b000;
    wait_cyc(t0 + 13);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_clear_busy_in_dwell: got %b, expected 1", bus.busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.sel !== 2'd1) begin
      failures++;
      $display("FAIL mid_clear_idle: got busy=%b sel=%0d, expected 0 1", bus.busy, bus.sel);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (strobe_q.size() + round_q.size() + err_q.size() != 0) begin
      failures++;
      $display("FAIL mask_err_missing_events: got %0d outstanding, expected 0",
               strobe_q.size() + round_q.size() + err_q.size());
    end
    strobe_q.delete(); round_q.delete(); err_q.delete();
  endtask

  task automatic test_stop();
    int t0;
    @(negedge clk);
    bus.enable_mask = 3'b111;
    bus.dwell       = 16'd4;
    bus.start       = 1'b1;
    t0 = cyc + 1;
    push_strobe(t0 + 2, 0);
    push_strobe(t0 + 9, 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(t0 + 9);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    checks++;
    if (bus.clken !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 2'd1) begin
      failures++;
      $display("FAIL stop_on_latch: got clken=%b busy=%b sel=%0d, expected 0 0 1", bus.clken, bus.busy, bus.sel);
    end
    // Stop in the last settle cycle must suppress the strobe entirely.
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(t0 + 1);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    checks++;
    if (bus.clken !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 2'd0) begin
      failures++;
      $display("FAIL stop_in_settle: got clken=%b busy=%b sel=%0d, expected 0 0 0", bus.clken, bus.busy, bus.sel);
    end
    @(negedge clk);
    bus.enable_mask = 3'b000;
    bus.start       = 1'b1;
    bus.stop        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.mask_err !== 1'b0) begin
      failures++;
      $display("FAIL start_stop_together: got busy=%b mask_err=%b, expected 0 0", bus.busy, bus.mask_err);
    end
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (strobe_q.size() + round_q.size() + err_q.size() != 0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_events: got %0d outstanding busy=%b, expected 0 0",
               strobe_q.size() + round_q.size() + err_q.size(), bus.busy);
    end
    strobe_q.delete(); round_q.delete(); err_q.delete();
  endtask

  task automatic test_reset_mid_run();
    int t0;
    @(negedge clk);
    bus.enable_mask = 3'b111;
    bus.dwell       = 16'd4;
    bus.start       = 1'b1;
    t0 = cyc + 1;
    push_strobe(t0 + 2, 0);
    push_strobe(t0 + 9, 1);
    @(negedge clk);
    bus.start = 1'b0;
    wait_cyc(t0 + 14);
    checks++;
    if (bus.sel !== 2'd2 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_settle: got sel=%0d busy=%b, expected 2 1", bus.sel, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.sel !== 2'd0 || bus.clken !== 1'b0 || bus.busy !== 1'b0 ||
        bus.round_done !== 1'b0 || bus.mask_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: got sel=%0d clken=%b busy=%b round_done=%b mask_err=%b, expected all 0",
               bus.sel, bus.clken, bus.busy, bus.round_done, bus.mask_err);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (strobe_q.size() + round_q.size() + err_q.size() != 0) begin
      failures++;
      $display("FAIL reset_run_events: got %0d outstanding, expected 0",
               strobe_q.size() + round_q.size() + err_q.size());
    end
    strobe_q.delete(); round_q.delete(); err_q.delete();
    run_rotation("resume", 3'b110, 16'd4, "121");
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.enable_mask = 3'b111;
    bus.dwell       = 16'd4;
    fork
      monitor();
    join_none
    test_reset();
    test_basic_rotation();
    test_sparse_mask();
    test_zero_dwell();
    test_mask_errors();
    test_stop();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
